// File: rtl/hovalaag_run_ctrl_if.sv
// CPU-side link of the Hovalaag run controller: generated clock/strobe out, OUT-port status and PC back.
interface hovalaag_run_ctrl_if;
    // out_valid qualifies out_select for one cpu cycle; there is no ready, the controller never back-pressures.
    logic       cpu_clk;
    logic       io_strobe;
    logic       out_valid;
    logic       out_select;
    logic [7:0] pc;

    modport master (
        output cpu_clk,
        output io_strobe,
        input  out_valid,
        input  out_select,
        input  pc
    );

    modport slave (
        input  cpu_clk,
        input  io_strobe,
        output out_valid,
        output out_select,
        output pc
    );
endinterface

// File: rtl/hovalaag_run_ctrl.sv
// Run/step/pause controller generating the Hovalaag cpu_clk and io_strobe from the board clock.
// Optional breakpoint support is compiled in with `define HOVALAAG_BREAKPOINT_EN.
module hovalaag_run_ctrl #(
    parameter int CNT_W     = 24,
    parameter int HALF_FAST = 4,
    parameter int HALF_MED  = 2097152,
    parameter int HALF_SLOW = 16777215,
    parameter int HALF_STEP = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run_en,
    input  logic [1:0]             speed,
    input  logic                   step_btn,
    input  logic                   cont_btn,
    input  logic                   pause_on_out1,
    input  logic                   bp_en,
    input  logic [7:0]             bp_addr,
    output logic                   paused,
    output logic                   bp_hit,
    output logic [2:0]             state,
    hovalaag_run_ctrl_if.master    cpu
);
    typedef enum logic [2:0] {
        STOPPED = 3'd0,
        RUN     = 3'd1,
        STEP_HI = 3'd2,
        STEP_LO = 3'd3,
        PAUSED  = 3'd4
    } state_t;

    // Counter counts down to zero, so a half-period of N clks reloads N-1.
    localparam logic [CNT_W-1:0] RLD_FAST = CNT_W'(HALF_FAST - 1);
    localparam logic [CNT_W-1:0] RLD_MED  = CNT_W'(HALF_MED - 1);
    localparam logic [CNT_W-1:0] RLD_SLOW = CNT_W'(HALF_SLOW - 1);
    localparam logic [CNT_W-1:0] RLD_STEP = CNT_W'(HALF_STEP - 1);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload;
    logic             clk_q;
    logic             clk_d1;
    logic             strobe_q;
    logic             paused_q;
    logic             bp_hit_q;
    logic [2:0]       step_sync;
    logic [2:0]       cont_sync;
    logic             step_edge;
    logic             cont_edge;
    logic             active;
    logic             out1_pause;
    logic             bp_trig;
    logic             pause_go;

    assign step_edge  = step_sync[1] & ~step_sync[2];
    assign cont_edge  = cont_sync[1] & ~cont_sync[2];
    assign active     = (st == RUN) || (st == STEP_HI) || (st == STEP_LO);
    assign out1_pause = cpu.out_valid & ~cpu.out_select & pause_on_out1;

`ifdef HOVALAAG_BREAKPOINT_EN
    assign bp_trig = strobe_q & bp_en & (cpu.pc == bp_addr) & ((st == RUN) || (st == STEP_LO));
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en, bp_addr, cpu.pc};
    assign bp_trig   = 1'b0;
`endif

    assign pause_go = (active & out1_pause) | bp_trig;

    always_comb begin
        reload = RLD_SLOW;
        if (speed[1]) begin
            reload = RLD_FAST;
        end else if (speed[0]) begin
            reload = RLD_MED;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st        <= STOPPED;
            cnt       <= '0;
            clk_q     <= 1'b0;
            clk_d1    <= 1'b0;
            strobe_q  <= 1'b0;
            paused_q  <= 1'b0;
            bp_hit_q  <= 1'b0;
            step_sync <= '0;
            cont_sync <= '0;
        end else begin
            step_sync <= {step_sync[1:0], step_btn};
            cont_sync <= {cont_sync[1:0], cont_btn};
            clk_d1    <= clk_q;
            strobe_q  <= clk_d1 & ~clk_q;

            // Pausing freezes cpu_clk and the counter exactly where they are.
            if (pause_go) begin
                st       <= PAUSED;
                paused_q <= 1'b1;
                if (bp_trig) begin
                    bp_hit_q <= 1'b1;
                end
            end else begin
                case (st)
                    STOPPED: begin
                        if (run_en) begin
                            st  <= RUN;
                            cnt <= reload;
                        end else if (step_edge) begin
                            st    <= STEP_HI;
                            clk_q <= 1'b1;
                            cnt   <= RLD_STEP;
                        end
                    end
                    RUN: begin
                        // Stopping waits for the low phase so a high phase is never cut short.
                        if (!run_en && !clk_q) begin
                            st <= STOPPED;
                        end else if (cnt == '0) begin
                            clk_q <= ~clk_q;
                            cnt   <= reload;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    STEP_HI: begin
                        if (cnt == '0) begin
                            st    <= STEP_LO;
                            clk_q <= 1'b0;
                            cnt   <= RLD_STEP;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    STEP_LO: begin
                        if (cnt == '0) begin
                            st <= STOPPED;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (cont_edge && !out1_pause) begin
                            paused_q <= 1'b0;
                            bp_hit_q <= 1'b0;
                            if (run_en) begin
                                st <= RUN;
                            end else if (clk_q) begin
                                // Finish the pending high phase with a real falling edge.
                                st    <= STEP_LO;
                                clk_q <= 1'b0;
                                cnt   <= RLD_STEP;
                            end else begin
                                st <= STOPPED;
                            end
                        end
                    end
                    default: st <= STOPPED;
                endcase
            end
        end
    end

    assign cpu.cpu_clk   = clk_q;
    assign cpu.io_strobe = strobe_q;
    assign paused        = paused_q;
    assign bp_hit        = bp_hit_q;
    assign state         = st;
endmodule
